slave_out_port: RTL and testbench
=================================

Name: slave_out_port

Overview:
- Slave-side serial transmitter. Drives the `rx_data` / `s_valid` lines that the master input port samples, and honours the master's `m_ready`.
- The slave core loads words through a one-word holding register and requests a burst.
- After a single `s_valid`/`m_ready` handshake, the block shifts out `burst_size × WORD_SIZE` bits back-to-back, LSB first, one bit per clock.

Parameters:
- WORD_SIZE, 8, bits per word.
- BURST_SIZE, 15, width of the `burst_size` port (words per burst).
- TIMEOUT_CYCLES, 255, handshake timeout limit; used only with SOUT_HS_TIMEOUT_EN.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- m_ready  input  1  master ready, from bus.
- tx_start  input  1  core request to start a burst; sampled in IDLE only.
- burst_size  input  BURST_SIZE  number of words; latched on accepted tx_start.
- tx_word  input  WORD_SIZE  word from core.
- tx_word_valid  input  1  tx_word valid.
- tx_data  output  1  serial data to bus.
- s_valid  output  1  slave valid, to bus.
- word_ready  output  1  holding register empty; tx_word accepted when tx_word_valid && word_ready.
- tx_busy  output  1  high when state is not IDLE.
- tx_done  output  1  one-cycle pulse, burst complete.
- tx_underrun  output  1  sticky, holding register empty at a word boundary.
- tx_timeout  output  1  one-cycle pulse; only with SOUT_HS_TIMEOUT_EN, otherwise tied 0.

Behaviour:
- Reset values:
  - Outputs: tx_data=0, s_valid=0, word_ready=1, tx_busy=0, tx_done=0, tx_underrun=0, tx_timeout=0.
  - Internal: holding register empty, state IDLE, all counters 0.
- Holding register:
  - Loads on tx_word_valid && word_ready in any state.
  - Becomes empty when its word moves into the shift register.
  - word_ready is the registered inverse of the full flag.
- State IDLE:
  - On tx_start with burst_size != 0: latch burst_size, clear tx_underrun, go to WAIT_HS.
  - tx_start with burst_size == 0 is ignored; no outputs change.
  - tx_start outside IDLE is ignored.
- State WAIT_HS:
  - s_valid is registered. It is set on the edge after the holding register is seen full while in WAIT_HS.
  - On the edge E0 where s_valid && m_ready are both sampled high:
    - s_valid<=0.
    - tx_data<=hold[0]; hold[WORD_SIZE-1:1] moves to the shift register; holding register empties.
    - bit_cnt<=0, word_cnt<=0, go to SEND.
- State SEND:
  - Bit k of word w is driven on tx_data starting at edge E0 + w·WORD_SIZE + k and held for one cycle.
  - At each edge with bit_cnt < WORD_SIZE-1: shift the next bit out and increment bit_cnt.
  - At an edge with bit_cnt == WORD_SIZE-1 and word_cnt < burst-1: word_cnt++, bit_cnt<=0.
    - If the holding register is full: load its word and drive its bit 0.
    - If it is empty: set tx_underrun, transmit an all-zero word, stay in SEND. Burst length is preserved.
  - At an edge with bit_cnt == WORD_SIZE-1 and word_cnt == burst-1: tx_data<=0, tx_done pulses for 1 cycle, go to IDLE.
    - This pulse is the same edge on which the master samples the last bit.
- m_ready is ignored in SEND. No per-word handshake occurs.
- A word written during SEND (word_ready high) is the next word sent.
- Latency: first bit appears 1 cycle after the handshake edge. Burst occupies exactly burst_size·WORD_SIZE cycles.
- Reset mid-burst: immediate return to reset values. The partial word is discarded and the holding register is cleared.

Optional Feature:
SOUT_HS_TIMEOUT_EN
- Defined:
  - A counter runs while in WAIT_HS with s_valid=1 and m_ready=0.
  - On reaching TIMEOUT_CYCLES: s_valid<=0, tx_timeout pulses 1 cycle, return to IDLE.
  - The holding register keeps its word.
  - The counter clears on leaving WAIT_HS.
- Undefined: no counter; WAIT_HS waits indefinitely; tx_timeout is constant 0.

Test Plan:
- Single word: WORD_SIZE=8, load 0xA5, tx_start with burst_size=1, m_ready=1.
  - s_valid rises, drops at handshake.
  - tx_data = 1,0,1,0,0,1,0,1 on the 8 cycles after E0.
  - tx_done pulses at E0+8.
- Burst of 3 (0x01, 0x80, 0xFF), core refilling on word_ready:
  - 24 contiguous bits, LSB first, no gaps.
  - tx_underrun=0; single tx_done at E0+24.
- Delayed m_ready: m_ready held 0 for 10 cycles after s_valid=1.
  - s_valid stays 1, tx_data stays 0.
  - First bit appears 1 cycle after m_ready is sampled high.
- Underrun: burst_size=2, second word never written.
  - Word 1 sent correctly, then 8 zero bits.
  - tx_underrun=1 until the next accepted tx_start; tx_done at E0+16.
- Reset mid-burst: rst_n low at bit 3 of word 0.
  - All outputs at reset values immediately; word_ready=1.
  - A new burst afterwards transmits correctly.
- With SOUT_HS_TIMEOUT_EN, TIMEOUT_CYCLES=4, m_ready=0:
  - tx_timeout pulses after 4 cycles of s_valid, s_valid<=0, state IDLE.
  - word_ready=0 (word retained).

Source files
------------

// File: rtl/slave_out_port.sv
// Slave-side serial transmitter: one-word holding register, single s_valid/m_ready handshake,
// then burst_size*WORD_SIZE bits LSB first. Optional handshake timeout via SOUT_HS_TIMEOUT_EN.
module slave_out_port #(
    parameter int WORD_SIZE      = 8,
    parameter int BURST_SIZE     = 15,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m_ready,
    input  logic                  tx_start,
    input  logic [BURST_SIZE-1:0] burst_size,
    input  logic [WORD_SIZE-1:0]  tx_word,
    input  logic                  tx_word_valid,
    output logic                  tx_data,
    output logic                  s_valid,
    output logic                  word_ready,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic                  tx_underrun,
    output logic                  tx_timeout
);
    localparam int BIT_W = (WORD_SIZE > 2) ? $clog2(WORD_SIZE) : 1;
    localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(WORD_SIZE - 1);
    localparam logic [BIT_W-1:0]      BIT_ONE  = BIT_W'(1);
    localparam logic [BURST_SIZE-1:0] WORD_ONE = BURST_SIZE'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_HS = 2'd1,
        ST_SEND    = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [WORD_SIZE-1:0]   hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic [WORD_SIZE-2:0]   shift_q, shift_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [BURST_SIZE-1:0]  word_cnt_q, word_cnt_d;
    logic [BURST_SIZE-1:0]  burst_q, burst_d;
    logic                   tx_data_q, tx_data_d;
    logic                   s_valid_q, s_valid_d;
    logic                   word_ready_q, word_ready_d;
    logic                   tx_busy_q, tx_busy_d;
    logic                   tx_done_q, tx_done_d;
    logic                   underrun_q, underrun_d;
    logic                   timeout_q, timeout_d;
    logic                   hold_take_s;

`ifdef SOUT_HS_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    // Next-state and output logic for the transmit FSM and holding register
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        burst_d     = burst_q;
        tx_data_d   = 1'b0;
        s_valid_d   = 1'b0;
        tx_done_d   = 1'b0;
        underrun_d  = underrun_q;
        timeout_d   = 1'b0;
        hold_take_s = 1'b0;
`ifdef SOUT_HS_TIMEOUT_EN
        to_cnt_d    = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (tx_start && (burst_size != '0)) begin
                    burst_d    = burst_size;
                    underrun_d = 1'b0;
                    state_d    = ST_WAIT_HS;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_WAIT_HS: begin
                if (s_valid_q && m_ready) begin
                    tx_data_d   = hold_q[0];
                    shift_d     = hold_q[WORD_SIZE-1:1];
                    hold_take_s = 1'b1;
                    bit_cnt_d   = '0;
                    word_cnt_d  = '0;
                    state_d     = ST_SEND;
                end else begin
                    s_valid_d = s_valid_q | hold_full_q;
`ifdef SOUT_HS_TIMEOUT_EN
                    // s_valid already high here implies m_ready is low
                    if (s_valid_q) begin
                        if (to_cnt_q == TO_LAST) begin
                            s_valid_d = 1'b0;
                            timeout_d = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            to_cnt_d = to_cnt_q + TO_ONE;
                        end
                    end else begin
                        to_cnt_d = to_cnt_q;
                    end
`endif
                end
            end
            ST_SEND: begin
                if (bit_cnt_q != LAST_BIT) begin
                    tx_data_d = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                end else if (word_cnt_q != (burst_q - WORD_ONE)) begin
                    word_cnt_d = word_cnt_q + WORD_ONE;
                    bit_cnt_d  = '0;
                    if (hold_full_q) begin
                        tx_data_d   = hold_q[0];
                        shift_d     = hold_q[WORD_SIZE-1:1];
                        hold_take_s = 1'b1;
                    end else begin
                        // Empty holding register: keep burst length, send zeros
                        underrun_d = 1'b1;
                        tx_data_d  = 1'b0;
                        shift_d    = '0;
                    end
                end else begin
                    tx_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (tx_word_valid && word_ready_q) begin
            hold_d      = tx_word;
            hold_full_d = 1'b1;
        end else if (hold_take_s) begin
            hold_full_d = 1'b0;
        end else begin
            hold_full_d = hold_full_q;
        end

        word_ready_d = ~hold_full_d;
        tx_busy_d    = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            burst_q      <= '0;
            tx_data_q    <= 1'b0;
            s_valid_q    <= 1'b0;
            word_ready_q <= 1'b1;
            tx_busy_q    <= 1'b0;
            tx_done_q    <= 1'b0;
            underrun_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            burst_q      <= burst_d;
            tx_data_q    <= tx_data_d;
            s_valid_q    <= s_valid_d;
            word_ready_q <= word_ready_d;
            tx_busy_q    <= tx_busy_d;
            tx_done_q    <= tx_done_d;
            underrun_q   <= underrun_d;
            timeout_q    <= timeout_d;
        end
    end

`ifdef SOUT_HS_TIMEOUT_EN
    // Handshake timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    assign tx_data     = tx_data_q;
    assign s_valid     = s_valid_q;
    assign word_ready  = word_ready_q;
    assign tx_busy     = tx_busy_q;
    assign tx_done     = tx_done_q;
    assign tx_underrun = underrun_q;
    assign tx_timeout  = timeout_q;

endmodule

// File: tb/tb_slave_out_port.sv
// Directed bench for slave_out_port: words handed to the core push their bits into a
// scoreboard queue, popped and compared as tx_data shifts out.
module tb_slave_out_port;
    localparam int WS = 8;
    localparam int BS = 15;
`ifdef SOUT_HS_TIMEOUT_EN
    localparam int HS_DELAY = 2;
`else
    localparam int HS_DELAY = 10;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m_ready = 1'b0;
    logic          tx_start = 1'b0;
    logic [BS-1:0] burst_size = '0;
    logic [WS-1:0] tx_word = '0;
    logic          tx_word_valid = 1'b0;
    logic          tx_data, s_valid, word_ready, tx_busy, tx_done, tx_underrun, tx_timeout;

    int n_cmp = 0;
    int n_bad = 0;
    logic          exp_q[$];
    logic [WS-1:0] core_q[$];

    slave_out_port #(.WORD_SIZE(WS), .BURST_SIZE(BS), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .m_ready(m_ready), .tx_start(tx_start),
        .burst_size(burst_size), .tx_word(tx_word), .tx_word_valid(tx_word_valid),
        .tx_data(tx_data), .s_valid(s_valid), .word_ready(word_ready), .tx_busy(tx_busy),
        .tx_done(tx_done), .tx_underrun(tx_underrun), .tx_timeout(tx_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Core side: hand over the next queued word whenever the holding register is free
    task automatic core_drive();
        logic [WS-1:0] w;
        if (core_q.size() > 0 && word_ready === 1'b1) begin
            w = core_q.pop_front();
            tx_word = w;
            tx_word_valid = 1'b1;
            for (int i = 0; i < WS; i++) exp_q.push_back(w[i]);
        end else begin
            tx_word_valid = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        core_drive();
    endtask

    task automatic start_burst(input logic [BS-1:0] n);
        step();
        tx_start = 1'b1;
        burst_size = n;
        step();
        tx_start = 1'b0;
    endtask

    // Wait for s_valid, keep m_ready low for 'delay' cycles of s_valid, then accept
    task automatic wait_hs(input int delay);
        int  seen = 0;
        bit  ok = 1'b0;
        for (int c = 0; c < 64 && !ok; c++) begin
            step();
            if (s_valid === 1'b1) begin
                if (seen >= delay) begin
                    m_ready = 1'b1;
                    ok = 1'b1;
                end else begin
                    check("hs_wait_data", 32'(tx_data), 32'd0);
                    check("hs_wait_tmo", 32'(tx_timeout), 32'd0);
                    seen++;
                end
            end
        end
        if (!ok) check("hs_bound", 32'(s_valid), 32'd1);
    endtask

    // Compare n serial bits following the handshake edge, then the done pulse
    task automatic run_bits(input int n);
        logic e;
        for (int k = 0; k < n; k++) begin
            step();
            if (k == 0) begin
                check("sv_drop", 32'(s_valid), 32'd0);
                check("busy_send", 32'(tx_busy), 32'd1);
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            check($sformatf("bit%0d", k), 32'(tx_data), 32'(e));
            check($sformatf("nodone%0d", k), 32'(tx_done), 32'd0);
        end
        step();
        check("done_pulse", 32'(tx_done), 32'd1);
        check("done_data", 32'(tx_data), 32'd0);
        check("done_idle", 32'(tx_busy), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        step();
        check("done_clear", 32'(tx_done), 32'd0);
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_sv", 32'(s_valid), 32'd0);
        check("rst_wr", 32'(word_ready), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_unr", 32'(tx_underrun), 32'd0);
        check("rst_tmo", 32'(tx_timeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word 0xA5
        m_ready = 1'b1;
        core_q.push_back(8'hA5);
        step();
        start_burst(15'd1);
        wait_hs(0);
        run_bits(8);

        // Burst of three with refill on word_ready
        core_q.push_back(8'h01);
        core_q.push_back(8'h80);
        core_q.push_back(8'hFF);
        step();
        start_burst(15'd3);
        wait_hs(0);
        run_bits(24);
        check("b3_unr", 32'(tx_underrun), 32'd0);

        // Delayed m_ready
        m_ready = 1'b0;
        core_q.push_back(8'hC3);
        step();
        start_burst(15'd1);
        wait_hs(HS_DELAY);
        run_bits(8);

        // Underrun: second word never supplied
        m_ready = 1'b1;
        core_q.push_back(8'h96);
        step();
        start_burst(15'd2);
        for (int i = 0; i < WS; i++) exp_q.push_back(1'b0);
        wait_hs(0);
        run_bits(16);
        check("unr_set", 32'(tx_underrun), 32'd1);

        // Zero-length start is ignored; underrun stays sticky
        start_burst(15'd0);
        step();
        check("zero_busy", 32'(tx_busy), 32'd0);
        check("zero_sv", 32'(s_valid), 32'd0);
        check("unr_sticky", 32'(tx_underrun), 32'd1);

        // Reset mid-burst at bit 3 of word 0
        core_q.push_back(8'h3C);
        step();
        start_burst(15'd2);
        check("unr_clear", 32'(tx_underrun), 32'd0);
        wait_hs(0);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("rb_bit%0d", k), 32'(tx_data), 32'(exp_q.pop_front()));
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", 32'(tx_data), 32'd0);
        check("mid_rst_wr", 32'(word_ready), 32'd1);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        check("mid_rst_sv", 32'(s_valid), 32'd0);
        exp_q.delete();
        core_q.delete();
        tx_word_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        core_q.push_back(8'h5A);
        step();
        start_burst(15'd1);
        wait_hs(0);
        run_bits(8);

`ifdef SOUT_HS_TIMEOUT_EN
        // Handshake timeout with TIMEOUT_CYCLES = 4
        m_ready = 1'b0;
        core_q.push_back(8'h77);
        step();
        start_burst(15'd1);
        begin
            bit seen_sv = 1'b0;
            for (int c = 0; c < 20 && !seen_sv; c++) begin
                step();
                if (s_valid === 1'b1) seen_sv = 1'b1;
            end
            check("tmo_sv_seen", 32'(s_valid), 32'd1);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            check("tmo_sv_hold", 32'(s_valid), 32'd1);
            check("tmo_early", 32'(tx_timeout), 32'd0);
        end
        step();
        check("tmo_pulse", 32'(tx_timeout), 32'd1);
        check("tmo_sv_drop", 32'(s_valid), 32'd0);
        check("tmo_idle", 32'(tx_busy), 32'd0);
        check("tmo_wr", 32'(word_ready), 32'd0);
        step();
        check("tmo_clear", 32'(tx_timeout), 32'd0);
        exp_q.delete();
`else
        check("tmo_tied", 32'(tx_timeout), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
